// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared constants for the PWM fade controller.
//   - Register addresses seen on the SPI write port.
//   - Fade engine state encoding.
package pwm_ctrl_pkg;

  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_DUTY      = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } fade_state_e;

endpackage

// File: rtl/pwm_fade_controller_if.sv
// pwm_fade_controller_if: bundles the SPI write strobe and the fade
// configuration inputs of pwm_fade_controller.
//   master : drives the write strobe and fade settings (SPI side / bench)
//   slave  : receives them (controller side)
// Write strobe: spi_wr_valid is a single-cycle strobe with no ready; the
// controller always accepts it, and addr/data are only meaningful while
// valid is high.
interface pwm_fade_controller_if
  import pwm_ctrl_pkg::*;
#(
  parameter int DIV_W = 16
);
  logic              spi_wr_valid;
  logic [ADDR_W-1:0] spi_wr_addr;
  logic [7:0]        spi_wr_data;
  logic              fade_en;
  logic [7:0]        fade_lo;
  logic [7:0]        fade_hi;
  logic [7:0]        fade_step;
  logic [DIV_W-1:0]  fade_div;

  modport master (
    output spi_wr_valid, spi_wr_addr, spi_wr_data,
    output fade_en, fade_lo, fade_hi, fade_step, fade_div
  );

  modport slave (
    input spi_wr_valid, spi_wr_addr, spi_wr_data,
    input fade_en, fade_lo, fade_hi, fade_step, fade_div
  );
endinterface

// File: rtl/fade_prescaler.sv
// fade_prescaler: tick generator for the fade engine.
//   clk, rst_n : clock, async active-low reset
//   run        : count while high; counter is held at 0 while low
//   div        : tick period minus one (0 = tick every cycle)
//   tick       : high in the cycle where the count equals div
module fade_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count_q, count_d;

  // div is sampled live; wrapping on >= keeps the counter from running
  // off to 2^DIV_W if div is lowered below the current count.
  always_comb begin
    count_d = count_q;
    if (!run) begin
      count_d = '0;
    end else if (count_q >= div) begin
      count_d = '0;
    end else begin
      count_d = count_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign tick = run && (count_q == div);

endmodule

// File: rtl/pwm_fade_controller.sv
// pwm_fade_controller: owns the five PWM configuration registers and
// arbitrates the duty register between SPI writes and a fade engine.
//   clk, rst_n               : clock, async active-low reset
//   spi_wr_valid/addr/data   : SPI register write strobe (addr 0-4 valid)
//   fade_en                  : level, runs the fade engine
//   fade_lo/hi/step/div      : live fade bounds, increment and tick period
//   en_reg_*, pwm_duty_cycle : registered configuration outputs
//   fade_active, fade_dir    : registered engine state (UP=11, DOWN=10,
//                              IDLE=00), doubling as the FSM state view
//   collision                : sticky, SPI duty write met an engine update
module pwm_fade_controller
  import pwm_ctrl_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_wr_valid,
  input  logic [2:0]       spi_wr_addr,
  input  logic [7:0]       spi_wr_data,
  input  logic             fade_en,
  input  logic [7:0]       fade_lo,
  input  logic [7:0]       fade_hi,
  input  logic [7:0]       fade_step,
  input  logic [DIV_W-1:0] fade_div,
  output logic [7:0]       en_reg_out_7_0,
  output logic [7:0]       en_reg_out_15_8,
  output logic [7:0]       en_reg_pwm_7_0,
  output logic [7:0]       en_reg_pwm_15_8,
  output logic [7:0]       pwm_duty_cycle,
  output logic             fade_active,
  output logic             fade_dir,
  output logic             collision
);

  fade_state_e state_q, state_d;
  logic [7:0]  duty_q, duty_d;
  logic        collision_q, collision_d;
  logic        active_q, dir_q;
  logic [7:0]  out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q;

  logic       run, tick, spi_duty_wr;
  logic       eng_wr;
  logic [7:0] eng_duty;
  logic [8:0] sum9, diff9;
  logic [7:0] up_next, down_next;
  logic       bounds_bad;

  // A dropping fade_en stops the prescaler in the same cycle, so a tick
  // coinciding with the deassert never reaches the engine.
  assign run         = (state_q != IDLE) && fade_en;
  assign spi_duty_wr = spi_wr_valid && (spi_wr_addr == ADDR_DUTY);

  fade_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .div   (fade_div),
    .tick  (tick)
  );

  // 9-bit arithmetic: bit 8 of sum is overflow, bit 8 of diff is borrow.
  assign sum9       = {1'b0, duty_q} + {1'b0, fade_step};
  assign diff9      = {1'b0, duty_q} - {1'b0, fade_step};
  assign up_next    = (sum9 > {1'b0, fade_hi}) ? fade_hi : sum9[7:0];
  assign down_next  = (diff9[8] || (diff9[7:0] < fade_lo)) ? fade_lo : diff9[7:0];
  assign bounds_bad = (fade_lo >= fade_hi);

  always_comb begin
    state_d     = state_q;
    eng_wr      = 1'b0;
    eng_duty    = duty_q;
    collision_d = collision_q;
    duty_d      = duty_q;

    unique case (state_q)
      IDLE: begin
        if (fade_en) begin
          state_d  = UP;
          eng_wr   = 1'b1;
          eng_duty = fade_lo;
        end
      end
      UP: begin
        if (!fade_en) begin
          state_d = IDLE;
        end else if (tick) begin
          eng_wr = 1'b1;
          if (bounds_bad) begin
            eng_duty = fade_lo;
            state_d  = DOWN;
          end else begin
            eng_duty = up_next;
            if (up_next == fade_hi) state_d = DOWN;
          end
        end
      end
      DOWN: begin
        if (!fade_en) begin
          state_d = IDLE;
        end else if (tick) begin
          eng_wr = 1'b1;
          if (bounds_bad) begin
            eng_duty = fade_lo;
            state_d  = UP;
          end else begin
            eng_duty = down_next;
            if (down_next == fade_lo) state_d = UP;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // SPI owns the duty register whenever it writes it; a tick-cycle update
    // is thrown away whole (value and direction change) and flagged.
    if (spi_duty_wr) begin
      duty_d = spi_wr_data;
      if (tick) begin
        state_d     = state_q;
        collision_d = 1'b1;
      end
    end else if (eng_wr) begin
      duty_d = eng_duty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      duty_q      <= '0;
      collision_q <= 1'b0;
      active_q    <= 1'b0;
      dir_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      collision_q <= collision_d;
      active_q    <= (state_d != IDLE);
      dir_q       <= (state_d == UP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_lo_q <= '0;
      out_hi_q <= '0;
      pwm_lo_q <= '0;
      pwm_hi_q <= '0;
    end else if (spi_wr_valid) begin
      if (spi_wr_addr == ADDR_EN_OUT_LO) out_lo_q <= spi_wr_data;
      if (spi_wr_addr == ADDR_EN_OUT_HI) out_hi_q <= spi_wr_data;
      if (spi_wr_addr == ADDR_EN_PWM_LO) pwm_lo_q <= spi_wr_data;
      if (spi_wr_addr == ADDR_EN_PWM_HI) pwm_hi_q <= spi_wr_data;
    end
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign fade_active     = active_q;
  assign fade_dir        = dir_q;
  assign collision       = collision_q;

endmodule

// File: tb/tb_pwm_fade_controller.sv
module tb_pwm_fade_controller;
  import pwm_ctrl_pkg::*;

  localparam int DIV_W = 16;

  logic clk;
  logic rst_n;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       fade_active, fade_dir, collision;

  int checks;
  int failures;

  logic [7:0] exp_q[$];
  logic       exp_dir_q[$];

  pwm_fade_controller_if #(.DIV_W(DIV_W)) bus ();

  pwm_fade_controller #(.DIV_W(DIV_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .spi_wr_valid    (bus.spi_wr_valid),
    .spi_wr_addr     (bus.spi_wr_addr),
    .spi_wr_data     (bus.spi_wr_data),
    .fade_en         (bus.fade_en),
    .fade_lo         (bus.fade_lo),
    .fade_hi         (bus.fade_hi),
    .fade_step       (bus.fade_step),
    .fade_div        (bus.fade_div),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .fade_active     (fade_active),
    .fade_dir        (fade_dir),
    .collision       (collision)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    check({tag, "_r0"}, 32'(en_reg_out_7_0),  32'(e0));
    check({tag, "_r1"}, 32'(en_reg_out_15_8), 32'(e1));
    check({tag, "_r2"}, 32'(en_reg_pwm_7_0),  32'(e2));
    check({tag, "_r3"}, 32'(en_reg_pwm_15_8), 32'(e3));
    check({tag, "_r4"}, 32'(pwm_duty_cycle),  32'(e4));
  endtask

  // ---------------- drivers ----------------
  // Drives one write strobe at a falling edge; returns at the next falling
  // edge, half a cycle after the capturing rising edge.
  task automatic spi_write(input logic [2:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.spi_wr_valid = 1'b1;
    bus.spi_wr_addr  = addr;
    bus.spi_wr_data  = data;
    @(negedge clk);
    bus.spi_wr_valid = 1'b0;
  endtask

  task automatic set_fade(input logic [7:0] lo, input logic [7:0] hi,
                          input logic [7:0] step, input logic [DIV_W-1:0] div);
    bus.fade_lo   = lo;
    bus.fade_hi   = hi;
    bus.fade_step = step;
    bus.fade_div  = div;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] exp_d;
    logic       exp_dir;
    logic [7:0] prev_d;

    checks   = 0;
    failures = 0;
    bus.spi_wr_valid = 1'b0;
    bus.spi_wr_addr  = '0;
    bus.spi_wr_data  = '0;
    bus.fade_en      = 1'b0;
    set_fade(8'h00, 8'h00, 8'h00, '0);

    rst_n = 1'b0;
    #2;
    check_regs("rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("rst_active", 32'(fade_active), 32'd0);
    check("rst_dir",    32'(fade_dir),    32'd0);
    check("rst_coll",   32'(collision),   32'd0);
    #10 rst_n = 1'b1;

    // ---- SPI register writes ----
    spi_write(ADDR_EN_OUT_LO, 8'hA5);
    check_regs("wr0", 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00);
    spi_write(ADDR_DUTY, 8'h80);
    check_regs("wr4", 8'hA5, 8'h00, 8'h00, 8'h00, 8'h80);
    spi_write(3'd6, 8'hFF);
    check_regs("wr6", 8'hA5, 8'h00, 8'h00, 8'h00, 8'h80);
    spi_write(ADDR_EN_OUT_HI, 8'h5A);
    spi_write(ADDR_EN_PWM_LO, 8'h3C);
    spi_write(ADDR_EN_PWM_HI, 8'hC3);
    check_regs("wr123", 8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h80);
    check("idle_active", 32'(fade_active), 32'd0);

    // ---- triangle ramp lo=10 hi=40 step=10 div=3 ----
    exp_q     = '{8'h20, 8'h30, 8'h40, 8'h30, 8'h20, 8'h10, 8'h20, 8'h30};
    exp_dir_q = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
    set_fade(8'h10, 8'h40, 8'h10, 16'd3);
    bus.fade_en = 1'b1;
    @(negedge clk);
    check("ramp_load",   32'(pwm_duty_cycle), 32'h10);
    check("ramp_active", 32'(fade_active),    32'd1);
    check("ramp_dir0",   32'(fade_dir),       32'd1);
    prev_d = 8'h10;
    while (exp_q.size() > 0) begin
      exp_d   = exp_q.pop_front();
      exp_dir = exp_dir_q.pop_front();
      repeat (3) @(negedge clk);
      check("ramp_hold", 32'(pwm_duty_cycle), 32'(prev_d));
      @(negedge clk);
      check("ramp_duty", 32'(pwm_duty_cycle), 32'(exp_d));
      check("ramp_dir",  32'(fade_dir),       32'(exp_dir));
      prev_d = exp_d;
    end

    // ---- fade_en drop at duty 30, then re-enable ----
    bus.fade_en = 1'b0;
    @(negedge clk);
    check("drop_active", 32'(fade_active),    32'd0);
    check("drop_dir",    32'(fade_dir),       32'd0);
    check("drop_duty",   32'(pwm_duty_cycle), 32'h30);
    repeat (6) @(negedge clk);
    check("drop_hold",   32'(pwm_duty_cycle), 32'h30);
    bus.fade_en = 1'b1;
    @(negedge clk);
    check("reen_duty",   32'(pwm_duty_cycle), 32'h10);
    check("reen_dir",    32'(fade_dir),       32'd1);
    bus.fade_en = 1'b0;
    @(negedge clk);

    // ---- saturation: lo=00 hi=FF step=F0 div=0 ----
    exp_q     = '{8'h00, 8'hF0, 8'hFF, 8'h0F, 8'h00};
    exp_dir_q = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b1};
    set_fade(8'h00, 8'hFF, 8'hF0, 16'd0);
    bus.fade_en = 1'b1;
    while (exp_q.size() > 0) begin
      exp_d   = exp_q.pop_front();
      exp_dir = exp_dir_q.pop_front();
      @(negedge clk);
      check("sat_duty", 32'(pwm_duty_cycle), 32'(exp_d));
      check("sat_dir",  32'(fade_dir),       32'(exp_dir));
    end
    check("pre_coll", 32'(collision), 32'd0);

    // ---- collision: SPI duty write in a tick cycle (state UP) ----
    bus.spi_wr_valid = 1'b1;
    bus.spi_wr_addr  = ADDR_DUTY;
    bus.spi_wr_data  = 8'h77;
    @(negedge clk);
    bus.spi_wr_valid = 1'b0;
    check("coll_duty", 32'(pwm_duty_cycle), 32'h77);
    check("coll_flag", 32'(collision),      32'd1);
    check("coll_dir",  32'(fade_dir),       32'd1);
    @(negedge clk);
    check("coll_next", 32'(pwm_duty_cycle), 32'hFF);
    check("coll_dir2", 32'(fade_dir),       32'd0);
    check("coll_stky", 32'(collision),      32'd1);
    @(negedge clk);
    check("coll_down", 32'(pwm_duty_cycle), 32'h0F);

    // ---- async reset mid-ramp, no clock edge ----
    #2 rst_n = 1'b0;
    #1;
    check_regs("arst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("arst_active", 32'(fade_active), 32'd0);
    check("arst_dir",    32'(fade_dir),    32'd0);
    check("arst_coll",   32'(collision),   32'd0);
    bus.fade_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_duty", 32'(pwm_duty_cycle), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
